mem_frame_writer: RTL and testbench

Burst-write initiator that captures a word stream and stores it as frames in external memory through the memory controller's user write-burst interface. It sits on the write side of the frame buffer. It fills three fixed frame regions, one BURST_SIZE-word block at a time, and raises `write_allframe_done` for the frame reader and UART path that drain the same regions.

---
 rtl/mem_frame_writer_if.sv | 33 +++
 rtl/mem_frame_writer.sv | 125 ++++++++++++
 tb/tb_mem_frame_writer.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_frame_writer_if.sv
// Bundles the capture stream, the controller write-burst port and the frame status.
// master = the frame writer, slave = the word source plus the memory controller.
// Pure wiring: no logic and no latency.
interface mem_frame_writer_if #(
    parameter int MEM_DATA_BITS = 32,
    parameter int ADDR_BITS     = 23,
    parameter int BUSRT_BITS    = 10
);
    logic                     write_start;
    logic                     in_valid;
    logic [MEM_DATA_BITS-1:0] in_data;
    logic                     in_ready;
    logic                     wr_burst_req;
    logic [BUSRT_BITS-1:0]    wr_burst_len;
    logic [ADDR_BITS-1:0]     wr_burst_addr;
    logic                     wr_burst_data_req;
    logic [MEM_DATA_BITS-1:0] wr_burst_data;
    logic                     wr_burst_finish;
    logic [1:0]               frame_writecnt;
    logic                     write_allframe_done;

    modport master (
        input  write_start, in_valid, in_data, wr_burst_data_req, wr_burst_finish,
        output in_ready, wr_burst_req, wr_burst_len, wr_burst_addr, wr_burst_data,
               frame_writecnt, write_allframe_done
    );

    modport slave (
        output write_start, in_valid, in_data, wr_burst_data_req, wr_burst_finish,
        input  in_ready, wr_burst_req, wr_burst_len, wr_burst_addr, wr_burst_data,
               frame_writecnt, write_allframe_done
    );
endinterface

// File: rtl/mem_frame_writer.sv
// Captures BURST_SIZE words into a local buffer, then writes them as one burst into three frame regions.
// Latency: burst request the cycle after the last captured word; burst data one cycle after each data request.
// Backpressure: in_ready is low while a burst is in flight. MEM_FRAME_WRITER_WRAP_EN makes capture a ring over the frames.
module mem_frame_writer #(
    parameter int MEM_DATA_BITS = 32,
    parameter int ADDR_BITS     = 23,
    parameter int BUSRT_BITS    = 10,
    parameter int BURST_SIZE    = 128,
    parameter int FRAME_BLOCKS  = 1280,
    parameter int FRAME_STRIDE  = 2073600
) (
    input  logic                mem_clk,
    input  logic                rst,
    mem_frame_writer_if.master  bus
);
    localparam int PTR_BITS = $clog2(BURST_SIZE);
    localparam logic [PTR_BITS-1:0] LAST_PTR = PTR_BITS'(BURST_SIZE - 1);
    localparam logic [10:0] LAST_BLOCK = 11'(FRAME_BLOCKS - 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_FILL    = 3'd1;
    localparam logic [2:0] S_WR_REQ  = 3'd2;
    localparam logic [2:0] S_WR_DATA = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;

    logic [2:0]               state;
    logic [PTR_BITS-1:0]      wptr;
    logic [PTR_BITS-1:0]      rptr;
    logic [10:0]              block_cnt;
    logic [1:0]               frame_idx;
    logic [1:0]               frame_writecnt;
    logic                     all_done;
    logic [MEM_DATA_BITS-1:0] burst_data;
    logic [MEM_DATA_BITS-1:0] buf_mem [BURST_SIZE];
    logic [ADDR_BITS-1:0]     frame_base;
    logic [ADDR_BITS-1:0]     block_off;

    // Status and burst control are decoded from state so reset clears them immediately.
    assign bus.in_ready            = (state == S_FILL);
    assign bus.wr_burst_req        = (state == S_WR_REQ);
    assign bus.wr_burst_len        = BUSRT_BITS'(BURST_SIZE);
    assign bus.wr_burst_data       = burst_data;
    assign bus.frame_writecnt      = frame_writecnt;
    assign bus.write_allframe_done = all_done;

    // Address math is truncated to ADDR_BITS on purpose.
    assign frame_base        = ADDR_BITS'(frame_idx) * ADDR_BITS'(FRAME_STRIDE);
    assign block_off         = ADDR_BITS'(block_cnt) * ADDR_BITS'(BURST_SIZE);
    assign bus.wr_burst_addr = frame_base + block_off;

    // Capture buffer write; contents need no reset because the pointers gate every use.
    always_ff @(posedge mem_clk) begin
        if (state == S_FILL && bus.in_valid) begin
            buf_mem[wptr] <= bus.in_data;
        end
    end

    // Control FSM: fill the buffer, run the burst, advance block/frame on finish.
    always_ff @(posedge mem_clk or posedge rst) begin
        if (rst) begin
            state          <= S_IDLE;
            wptr           <= '0;
            rptr           <= '0;
            block_cnt      <= '0;
            frame_idx      <= '0;
            frame_writecnt <= '0;
            all_done       <= 1'b0;
            burst_data     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.write_start) begin
                        state <= S_FILL;
                    end
                end
                S_FILL: begin
                    if (bus.in_valid) begin
                        if (wptr == LAST_PTR) begin
                            wptr  <= '0;
                            state <= S_WR_REQ;
                        end else begin
                            wptr <= wptr + 1'b1;
                        end
                    end
                end
                S_WR_REQ, S_WR_DATA: begin
                    // Serve the data word first; a coincident finish still sees it go out.
                    if (bus.wr_burst_data_req) begin
                        burst_data <= buf_mem[rptr];
                        if (rptr != LAST_PTR) begin
                            rptr <= rptr + 1'b1;
                        end
                        state <= S_WR_DATA;
                    end
                    if (bus.wr_burst_finish) begin
                        wptr  <= '0;
                        rptr  <= '0;
                        state <= S_FILL;
                        if (block_cnt == LAST_BLOCK) begin
                            block_cnt      <= '0;
                            frame_idx      <= frame_idx + 1'b1;
                            frame_writecnt <= (frame_writecnt == 2'd3) ? 2'd3 : frame_writecnt + 1'b1;
                            if (frame_idx == 2'd2) begin
                                all_done <= 1'b1;
`ifdef MEM_FRAME_WRITER_WRAP_EN
                                frame_idx <= 2'd0;
`else
                                state <= S_DONE;
`endif
                            end
                        end else begin
                            block_cnt <= block_cnt + 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    state <= S_DONE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_frame_writer.sv
// Scoreboard bench for mem_frame_writer with a reduced frame size (3 bursts per frame).
// Input words and burst addresses are queued as driven and compared as the controller side sees them.
// All driving and sampling happens at the falling clock edge.
module tb_mem_frame_writer;
    localparam int BS     = 128;
    localparam int FB     = 3;
    localparam int STRIDE = 2073600;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_frame_writer_if #(.MEM_DATA_BITS(32), .ADDR_BITS(23), .BUSRT_BITS(10)) bus ();

    mem_frame_writer #(
        .MEM_DATA_BITS(32), .ADDR_BITS(23), .BUSRT_BITS(10),
        .BURST_SIZE(BS), .FRAME_BLOCKS(FB), .FRAME_STRIDE(STRIDE)
    ) dut (
        .mem_clk (clk),
        .rst     (rst),
        .bus     (bus)
    );

    int checks = 0;
    int failures = 0;
    int burst_no = 0;
    logic [31:0] data_q[$];
    logic [22:0] addr_q[$];

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got=%0d expected=%0d", tag, act, exp);
        end
    endtask

    function automatic logic [22:0] exp_addr(input int n);
        int f = (n / FB) % 3;
        int b = n % FB;
        return 23'(f * STRIDE + b * BS);
    endfunction

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, bus.in_ready, 0);
        chk({tag, "_req"}, bus.wr_burst_req, 0);
        chk({tag, "_len"}, bus.wr_burst_len, BS);
        chk({tag, "_addr"}, bus.wr_burst_addr, 0);
        chk({tag, "_data"}, bus.wr_burst_data, 0);
        chk({tag, "_cnt"}, bus.frame_writecnt, 0);
        chk({tag, "_done"}, bus.write_allframe_done, 0);
    endtask

    // Drive one block of BS words starting at base; gappy makes in_valid toggle every cycle.
    task automatic fill_block(input bit gappy, input logic [31:0] base);
        int i = 0;
        bit g = 1'b0;
        addr_q.push_back(exp_addr(burst_no));
        burst_no++;
        while (i < BS) begin
            if (gappy && g) begin
                bus.in_valid = 1'b0;
            end else begin
                if (i == 0) chk("in_ready_fill", bus.in_ready, 1);
                bus.in_valid = 1'b1;
                bus.in_data  = base + 32'(i);
                data_q.push_back(base + 32'(i));
                i++;
            end
            g = ~g;
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        chk("req_rise", bus.wr_burst_req, 1);
    endtask

    // Act as the controller: pull BS+extra words, then finish (coincident with the last pull if asked).
    task automatic serve_burst(input bit gappy, input int extra, input bit coincident);
        int n = 0;
        int issued = 0;
        int cyc = 0;
        int total = BS + extra;
        bit pend = 1'b0;
        bit chk_drop = 1'b0;
        logic [31:0] pend_exp = '0;
        logic [31:0] last = '0;
        while (!bus.wr_burst_req && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("req_wait", bus.wr_burst_req, 1);
        if (!bus.wr_burst_req) return;
        chk("addr", bus.wr_burst_addr, addr_q.pop_front());
        chk("len", bus.wr_burst_len, BS);
        while (1) begin
            if (pend) begin
                chk("data", bus.wr_burst_data, pend_exp);
                pend = 1'b0;
            end
            if (chk_drop) begin
                chk("req_drop", bus.wr_burst_req, 0);
                chk_drop = 1'b0;
            end
            bus.wr_burst_data_req = 1'b0;
            bus.wr_burst_finish   = 1'b0;
            if (issued >= total) break;
            if (!(gappy && (cyc % 3 == 1))) begin
                bus.wr_burst_data_req = 1'b1;
                if (issued < BS) begin
                    pend_exp = (data_q.size() > 0) ? data_q.pop_front() : 32'hDEAD_BEEF;
                    last = pend_exp;
                end else begin
                    pend_exp = last;
                end
                pend = 1'b1;
                if (issued == 0) chk_drop = 1'b1;
                issued++;
                if (coincident && issued == total) bus.wr_burst_finish = 1'b1;
            end
            cyc++;
            @(negedge clk);
        end
        if (!coincident) begin
            bus.wr_burst_finish = 1'b1;
            @(negedge clk);
            bus.wr_burst_finish = 1'b0;
        end
    endtask

    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog: got=timeout expected=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.write_start       = 1'b0;
        bus.in_valid          = 1'b0;
        bus.in_data           = '0;
        bus.wr_burst_data_req = 1'b0;
        bus.wr_burst_finish   = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);
        chk("idle_in_ready", bus.in_ready, 0);

        bus.write_start = 1'b1;
        @(negedge clk);
        bus.write_start = 1'b0;
        chk("in_ready_after_start", bus.in_ready, 1);

        // Burst 0: back-to-back words and pulls.
        fill_block(1'b0, 32'd0);
        serve_burst(1'b0, 0, 1'b0);
        chk("b0_in_ready", bus.in_ready, 1);
        chk("b0_cnt", bus.frame_writecnt, 0);

        // Burst 1: 50% input valid, gaps in pulls, three extra pulls repeat the last word.
        fill_block(1'b1, 32'd1000);
        serve_burst(1'b1, 3, 1'b0);
        chk("b1_in_ready", bus.in_ready, 1);

        // Burst 2: finish coincident with the final pull; last block of frame 0.
        fill_block(1'b0, 32'd2000);
        serve_burst(1'b0, 0, 1'b1);
        chk("coinc_fill", bus.in_ready, 1);
        chk("frame0_cnt", bus.frame_writecnt, 1);
        chk("frame0_done", bus.write_allframe_done, 0);

        for (int k = 3; k < 3 * FB; k++) begin
            fill_block(k[0], 32'(k * 1000));
            serve_burst(k[0], 0, (k == 5));
            if (k == 5) chk("frame1_cnt", bus.frame_writecnt, 2);
        end
        chk("all_done", bus.write_allframe_done, 1);
        chk("all_cnt", bus.frame_writecnt, 3);
`ifdef MEM_FRAME_WRITER_WRAP_EN
        chk("wrap_in_ready", bus.in_ready, 1);
        fill_block(1'b0, 32'd9000);
        serve_burst(1'b0, 0, 1'b0);
        chk("wrap_done", bus.write_allframe_done, 1);
        chk("wrap_cnt", bus.frame_writecnt, 3);
`else
        bus.in_valid    = 1'b1;
        bus.write_start = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("done_in_ready", bus.in_ready, 0);
            chk("done_req", bus.wr_burst_req, 0);
        end
        bus.in_valid    = 1'b0;
        bus.write_start = 1'b0;
        chk("done_hold", bus.write_allframe_done, 1);
`endif

        // Reset in the middle of a burst's data phase.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        data_q.delete();
        addr_q.delete();
        burst_no = 0;
        bus.write_start = 1'b1;
        @(negedge clk);
        bus.write_start = 1'b0;
        fill_block(1'b0, 32'd5000);
        chk("abort_addr", bus.wr_burst_addr, addr_q.pop_front());
        for (int k = 0; k < 10; k++) begin
            bus.wr_burst_data_req = 1'b1;
            @(negedge clk);
            chk("abort_data", bus.wr_burst_data, data_q.pop_front());
        end
        rst = 1'b1;
        #1;
        bus.wr_burst_data_req = 1'b0;
        check_reset_outputs("midrst");
        @(negedge clk);
        rst = 1'b0;
        data_q.delete();
        addr_q.delete();
        burst_no = 0;
        @(negedge clk);
        bus.write_start = 1'b1;
        @(negedge clk);
        bus.write_start = 1'b0;
        fill_block(1'b0, 32'd6000);
        serve_burst(1'b0, 0, 1'b0);
        chk("restart_in_ready", bus.in_ready, 1);
        chk("restart_addr_next", bus.wr_burst_addr, exp_addr(1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
